hazard_detection: RTL and testbench
===================================

HAZARD_DETECTION -- requirements
Module: hazard_detection

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 SHALL have ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- IF_ID_rs  input  5  rs of the instruction in ID.
- IF_ID_rt  input  5  rt of the instruction in ID.
- ID_uses_rt  input  1  instruction in ID reads rt.
- ID_branch  input  1  instruction in ID is beq/bne, resolved in ID.
- ID_jump  input  1  instruction in ID is j/jal.
- branch_taken  input  1  ID comparator result.
- ID_EX_mem_read  input  1  instruction in EX is a load.
- ID_EX_reg_write  input  1  instruction in EX writes a register.
- ID_EX_rd  input  5  destination register of the instruction in EX.
- EX_MEM_mem_read  input  1  instruction in MEM is a load.
- EX_MEM_rd  input  5  destination register of the instruction in MEM.
- pc_write  output  1  PC update enable.
- IF_ID_write  output  1  IF/ID register load enable.
- ID_EX_flush  output  1  insert a bubble into ID/EX (zero its control fields).
- IF_ID_flush  output  1  squash the instruction in IF.
- stall_cycles  output  CNT_W  count of stall cycles.
- flush_count  output  CNT_W  count of control flushes.

Function
REQ-003 SHALL define match(r) = (r != 0) && (r == IF_ID_rs || (ID_uses_rt && r == IF_ID_rt)).
REQ-004 SHALL detect these hazards and required stall lengths:
- LU: ID_EX_mem_read && match(ID_EX_rd) -> 1 cycle.
- BA: ID_branch && ID_EX_reg_write && !ID_EX_mem_read && match(ID_EX_rd) -> 1 cycle.
- BL: ID_branch && ID_EX_mem_read && match(ID_EX_rd) -> 2 cycles.
- BM: ID_branch && EX_MEM_mem_read && match(EX_MEM_rd) -> 1 cycle.
REQ-005 SHALL take the required stall length as the maximum over all active hazards; simultaneous hazards SHALL NOT add.
REQ-006 SHALL implement FSM states RUN and HOLD; HOLD carries a 2-bit remaining-cycle counter.
REQ-007 In RUN with stall length 1, SHALL assert the stall outputs this cycle and stay in RUN.
REQ-008 In RUN with stall length 2, SHALL assert the stall outputs this cycle, go to HOLD, and load remaining=1.
REQ-009 In HOLD, SHALL assert the stall outputs while ignoring all hazard, branch and jump inputs; it SHALL decrement remaining and return to RUN when the counter reaches 0.
REQ-010 Stall outputs SHALL be pc_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0; otherwise pc_write=1, IF_ID_write=1, ID_EX_flush=0.
REQ-011 IF_ID_flush SHALL be 1 only in RUN with no hazard and (ID_jump || (ID_branch && branch_taken)).
REQ-012 Stall SHALL take priority over flush; branch_taken during any stall cycle SHALL be ignored.
REQ-013 All control outputs SHALL be combinational from the current state and inputs, with zero-cycle latency.
REQ-014 stall_cycles SHALL increment by 1 on each clock edge where ID_EX_flush=1, saturating at all-ones.
REQ-015 flush_count SHALL increment by 1 on each clock edge where IF_ID_flush=1, saturating at all-ones.

Reset
REQ-016 On a clk edge with rst=1, SHALL set state RUN, remaining=0, stall_cycles=0, flush_count=0.
REQ-017 While rst=1, SHALL drive pc_write=1, IF_ID_write=1, ID_EX_flush=0, IF_ID_flush=0, regardless of inputs.
REQ-018 Reset asserted while in HOLD SHALL abort the stall; the next cycle SHALL evaluate hazards in RUN.

Structure
REQ-019 SHALL place the state encoding (RUN, HOLD) and the stall-length constants (STALL_0/1/2) in a shared package, e.g. the pipeline control package.
REQ-020 SHALL instantiate the register match of REQ-003 from one sub-module, reg_match, instantiated twice (for the EX and MEM destinations).

Verification
REQ-021 SHALL cover load-use: lw $2 in EX (ID_EX_mem_read=1, ID_EX_rd=2), add with rs=2 in ID -> one cycle with pc_write=0, ID_EX_flush=1; next cycle pc_write=1; stall_cycles=1.
REQ-022 SHALL cover a branch after a load: ID_branch=1, rs=3, ID_EX_mem_read=1, ID_EX_rd=3 -> exactly 2 stall cycles with branch_taken=1 ignored, then IF_ID_flush=1 in RUN; stall_cycles=2, flush_count=1.
REQ-023 SHALL cover $zero: ID_EX_mem_read=1, ID_EX_rd=0, rs=0 -> no stall, pc_write=1.
REQ-024 SHALL cover rt unused: ID_uses_rt=0, rt=5, ID_EX_rd=5, load in EX -> no stall.
REQ-025 SHALL cover reset mid-HOLD: trigger BL, assert rst in the HOLD cycle -> state RUN, counters=0, pc_write=1 while rst=1.
REQ-026 SHALL cover saturation: CNT_W=2, drive 5 load-use stalls -> stall_cycles=3.

Source files
------------

// File: rtl/hazard_detection_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and stall lengths.
package hazard_detection_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef logic [1:0] stall_len_t;

    localparam stall_len_t STALL_0 = 2'd0;
    localparam stall_len_t STALL_1 = 2'd1;
    localparam stall_len_t STALL_2 = 2'd2;

    // Longer of two stall requirements; concurrent hazards overlap, never add.
    function automatic stall_len_t max_len(input stall_len_t a, input stall_len_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_detection_if.sv
// Pipeline-register view seen by the hazard unit, plus its control outputs.
interface hazard_detection_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_rs;
    logic [4:0]       IF_ID_rt;
    logic             ID_uses_rt;
    logic             ID_branch;
    logic             ID_jump;
    logic             branch_taken;
    logic             ID_EX_mem_read;
    logic             ID_EX_reg_write;
    logic [4:0]       ID_EX_rd;
    logic             EX_MEM_mem_read;
    logic [4:0]       EX_MEM_rd;
    logic             pc_write;
    logic             IF_ID_write;
    logic             ID_EX_flush;
    logic             IF_ID_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_branch, ID_jump, branch_taken,
               ID_EX_mem_read, ID_EX_reg_write, ID_EX_rd, EX_MEM_mem_read, EX_MEM_rd,
        input  pc_write, IF_ID_write, ID_EX_flush, IF_ID_flush, stall_cycles, flush_count
    );

    modport slave (
        input  IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_branch, ID_jump, branch_taken,
               ID_EX_mem_read, ID_EX_reg_write, ID_EX_rd, EX_MEM_mem_read, EX_MEM_rd,
        output pc_write, IF_ID_write, ID_EX_flush, IF_ID_flush, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_detection_reg_match.sv
// Does a producer destination register feed a source operand of the ID instruction?
// $zero never matches, and rt only counts when the instruction actually reads it.
module reg_match (
    input  logic [4:0] r,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       uses_rt,
    output logic       hit
);
    assign hit = (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
endmodule

// File: rtl/hazard_detection.sv
// Hazard detection unit: load-use and branch-operand stalls, control flushes,
// and saturating stall/flush performance counters.
module hazard_detection
    import hazard_detection_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_detection_if.slave bus
);

    logic       ex_hit_s;
    logic       mem_hit_s;
    stall_len_t stall_len_s;
    state_t     state_r;
    state_t     state_next_s;
    logic [1:0] remaining_r;
    logic [1:0] remaining_next_s;
    logic       pc_write_s;
    logic       if_id_write_s;
    logic       id_ex_flush_s;
    logic       if_id_flush_s;
    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] flush_count_r;

    reg_match u_match_ex (
        .r       (bus.ID_EX_rd),
        .rs      (bus.IF_ID_rs),
        .rt      (bus.IF_ID_rt),
        .uses_rt (bus.ID_uses_rt),
        .hit     (ex_hit_s)
    );

    reg_match u_match_mem (
        .r       (bus.EX_MEM_rd),
        .rs      (bus.IF_ID_rs),
        .rt      (bus.IF_ID_rt),
        .uses_rt (bus.ID_uses_rt),
        .hit     (mem_hit_s)
    );

    // Required stall length: the longest of all hazards currently active.
    always_comb begin
        stall_len_s = STALL_0;
        if (bus.ID_EX_mem_read && ex_hit_s) begin
            stall_len_s = max_len(stall_len_s, STALL_1);
        end else begin
            stall_len_s = stall_len_s;
        end
        if (bus.ID_branch && bus.ID_EX_reg_write && !bus.ID_EX_mem_read && ex_hit_s) begin
            stall_len_s = max_len(stall_len_s, STALL_1);
        end else begin
            stall_len_s = stall_len_s;
        end
        if (bus.ID_branch && bus.ID_EX_mem_read && ex_hit_s) begin
            stall_len_s = max_len(stall_len_s, STALL_2);
        end else begin
            stall_len_s = stall_len_s;
        end
        if (bus.ID_branch && bus.EX_MEM_mem_read && mem_hit_s) begin
            stall_len_s = max_len(stall_len_s, STALL_1);
        end else begin
            stall_len_s = stall_len_s;
        end
    end

    // State register; reset aborts any stall in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            remaining_r <= 2'd0;
        end else begin
            state_r     <= state_next_s;
            remaining_r <= remaining_next_s;
        end
    end

    // Next state: only a 2-cycle stall needs HOLD; HOLD counts down and ignores inputs.
    always_comb begin
        state_next_s     = state_r;
        remaining_next_s = remaining_r;
        case (state_r)
            RUN: begin
                if (stall_len_s == STALL_2) begin
                    state_next_s     = HOLD;
                    remaining_next_s = 2'd1;
                end else begin
                    state_next_s     = RUN;
                    remaining_next_s = 2'd0;
                end
            end
            HOLD: begin
                remaining_next_s = remaining_r - 2'd1;
                if (remaining_r <= 2'd1) begin
                    state_next_s     = RUN;
                    remaining_next_s = 2'd0;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s     = RUN;
                remaining_next_s = 2'd0;
            end
        endcase
    end

    // Control outputs: reset forces normal flow, stall beats flush, flush only in RUN.
    always_comb begin
        pc_write_s    = 1'b1;
        if_id_write_s = 1'b1;
        id_ex_flush_s = 1'b0;
        if_id_flush_s = 1'b0;
        if (rst) begin
            pc_write_s    = 1'b1;
            if_id_write_s = 1'b1;
        end else if ((state_r == HOLD) || (stall_len_s != STALL_0)) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            id_ex_flush_s = 1'b1;
        end else begin
            if_id_flush_s = bus.ID_jump || (bus.ID_branch && bus.branch_taken);
        end
    end

    // Saturating performance counters, one per bubble and one per squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= '0;
            flush_count_r  <= '0;
        end else begin
            if (id_ex_flush_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (if_id_flush_s && (flush_count_r != {CNT_W{1'b1}})) begin
                flush_count_r <= flush_count_r + CNT_W'(1);
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign bus.pc_write     = pc_write_s;
    assign bus.IF_ID_write  = if_id_write_s;
    assign bus.ID_EX_flush  = id_ex_flush_s;
    assign bus.IF_ID_flush  = if_id_flush_s;
    assign bus.stall_cycles = stall_cycles_r;
    assign bus.flush_count  = flush_count_r;

endmodule

// File: tb/tb_hazard_detection.sv
// Bench for hazard_detection: directed scenarios then random traffic, checked
// against a pending-stall-cycles reference model. A 2-bit-counter copy sees
// the same stimulus to exercise counter saturation.
module tb_hazard_detection;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] rs, rt, ex_rd, mem_rd;
    logic uses_rt, branch, jump, taken, ex_mem_read, ex_reg_write, mm_read;

    hazard_detection_if #(.CNT_W(16)) b16 ();
    hazard_detection_if #(.CNT_W(2))  b2  ();

    assign b16.IF_ID_rs = rs;          assign b2.IF_ID_rs = rs;
    assign b16.IF_ID_rt = rt;          assign b2.IF_ID_rt = rt;
    assign b16.ID_uses_rt = uses_rt;   assign b2.ID_uses_rt = uses_rt;
    assign b16.ID_branch = branch;     assign b2.ID_branch = branch;
    assign b16.ID_jump = jump;         assign b2.ID_jump = jump;
    assign b16.branch_taken = taken;   assign b2.branch_taken = taken;
    assign b16.ID_EX_mem_read = ex_mem_read;   assign b2.ID_EX_mem_read = ex_mem_read;
    assign b16.ID_EX_reg_write = ex_reg_write; assign b2.ID_EX_reg_write = ex_reg_write;
    assign b16.ID_EX_rd = ex_rd;       assign b2.ID_EX_rd = ex_rd;
    assign b16.EX_MEM_mem_read = mm_read;      assign b2.EX_MEM_mem_read = mm_read;
    assign b16.EX_MEM_rd = mem_rd;     assign b2.EX_MEM_rd = mem_rd;

    hazard_detection #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    hazard_detection #(.CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(b2));

    int pass_cnt = 0;
    int total = 0;

    // Reference model state: stall cycles still owed, and expected counters.
    int pending = 0;
    int sc16 = 0, fc16 = 0, sc2 = 0, fc2 = 0;
    logic e_pc, e_ifw, e_exf, e_iff;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit m(input logic [4:0] r);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    function automatic int need();
        int n = 0;
        if (ex_mem_read && m(ex_rd)) n = (n > 1) ? n : 1;
        if (branch && ex_reg_write && !ex_mem_read && m(ex_rd)) n = (n > 1) ? n : 1;
        if (branch && ex_mem_read && m(ex_rd)) n = 2;
        if (branch && mm_read && m(mem_rd)) n = (n > 1) ? n : 1;
        return n;
    endfunction

    // Compare all outputs of both copies with the model, mid-cycle.
    task automatic eval(input string tag);
        int n;
        @(negedge clk);
        n = need();
        if (rst) begin
            e_pc = 1'b1; e_ifw = 1'b1; e_exf = 1'b0; e_iff = 1'b0;
        end else if (pending > 0 || n > 0) begin
            e_pc = 1'b0; e_ifw = 1'b0; e_exf = 1'b1; e_iff = 1'b0;
        end else begin
            e_pc = 1'b1; e_ifw = 1'b1; e_exf = 1'b0; e_iff = jump || (branch && taken);
        end
        chk({tag, ".pc_write"},     {31'd0, b16.pc_write},    {31'd0, e_pc});
        chk({tag, ".IF_ID_write"},  {31'd0, b16.IF_ID_write}, {31'd0, e_ifw});
        chk({tag, ".ID_EX_flush"},  {31'd0, b16.ID_EX_flush}, {31'd0, e_exf});
        chk({tag, ".IF_ID_flush"},  {31'd0, b16.IF_ID_flush}, {31'd0, e_iff});
        chk({tag, ".stall16"},      {16'd0, b16.stall_cycles}, sc16);
        chk({tag, ".flush16"},      {16'd0, b16.flush_count},  fc16);
        chk({tag, ".stall2"},       {30'd0, b2.stall_cycles},  sc2);
        chk({tag, ".flush2"},       {30'd0, b2.flush_count},   fc2);
        chk({tag, ".pc_write2"},    {31'd0, b2.pc_write},      {31'd0, e_pc});
    endtask

    // Advance the model across the coming clock edge, then move past it.
    task automatic tick();
        int n = need();
        if (rst) begin
            pending = 0; sc16 = 0; fc16 = 0; sc2 = 0; fc2 = 0;
        end else begin
            if (pending > 0) pending--;
            else if (n > 0) pending = n - 1;
            if (e_exf) begin
                if (sc16 < 65535) sc16++;
                if (sc2 < 3) sc2++;
            end
            if (e_iff) begin
                if (fc16 < 65535) fc16++;
                if (fc2 < 3) fc2++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs = 5'd0; rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        uses_rt = 1'b0; branch = 1'b0; jump = 1'b0; taken = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; mm_read = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        eval("reset");
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;

        // Reset with a live hazard on the inputs still drives normal flow.
        ex_mem_read = 1'b1; ex_rd = 5'd4; rs = 5'd4; branch = 1'b1; taken = 1'b1;
        do_reset();
        chk("rst_pc_write", {31'd0, b16.pc_write}, 32'd1);
        idle();

        // Load-use: one bubble, then normal flow.
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd2; rs = 5'd2;
        eval("lu");
        chk("lu_pc_write", {31'd0, b16.pc_write}, 32'd0);
        chk("lu_ID_EX_flush", {31'd0, b16.ID_EX_flush}, 32'd1);
        tick();
        idle();
        eval("lu_after");
        chk("lu_after_pc_write", {31'd0, b16.pc_write}, 32'd1);
        chk("lu_stall_cycles", {16'd0, b16.stall_cycles}, 32'd1);
        tick();

        // Branch after load: two stalls ignoring branch_taken, then squash.
        do_reset();
        branch = 1'b1; rs = 5'd3; ex_mem_read = 1'b1; ex_rd = 5'd3; taken = 1'b1;
        eval("bl1");
        chk("bl1_IF_ID_flush", {31'd0, b16.IF_ID_flush}, 32'd0);
        tick();
        eval("bl2");
        chk("bl2_pc_write", {31'd0, b16.pc_write}, 32'd0);
        chk("bl2_IF_ID_flush", {31'd0, b16.IF_ID_flush}, 32'd0);
        tick();
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        eval("bl3");
        chk("bl3_IF_ID_flush", {31'd0, b16.IF_ID_flush}, 32'd1);
        tick();
        idle();
        eval("bl_done");
        chk("bl_stall_cycles", {16'd0, b16.stall_cycles}, 32'd2);
        chk("bl_flush_count", {16'd0, b16.flush_count}, 32'd1);
        tick();

        // $zero never creates a dependency.
        ex_mem_read = 1'b1; ex_rd = 5'd0; rs = 5'd0;
        eval("zero");
        chk("zero_pc_write", {31'd0, b16.pc_write}, 32'd1);
        tick();

        // rt ignored when the instruction does not read it.
        idle();
        ex_mem_read = 1'b1; rt = 5'd5; ex_rd = 5'd5; rs = 5'd1; uses_rt = 1'b0;
        eval("rt_unused");
        chk("rt_unused_pc_write", {31'd0, b16.pc_write}, 32'd1);
        tick();
        uses_rt = 1'b1;
        eval("rt_used");
        tick();

        // Reset during HOLD aborts the stall.
        idle();
        do_reset();
        branch = 1'b1; rs = 5'd7; ex_mem_read = 1'b1; ex_rd = 5'd7;
        eval("hold_rst1");
        tick();
        rst = 1'b1;
        eval("hold_rst2");
        chk("hold_rst_pc_write", {31'd0, b16.pc_write}, 32'd1);
        tick();
        rst = 1'b0;
        idle();
        eval("hold_rst3");
        chk("hold_rst_run_pc_write", {31'd0, b16.pc_write}, 32'd1);
        chk("hold_rst_stall_cycles", {16'd0, b16.stall_cycles}, 32'd0);
        tick();

        // Five load-use stalls: the 2-bit copy saturates at 3.
        ex_mem_read = 1'b1; ex_rd = 5'd9; rs = 5'd9;
        for (int i = 0; i < 5; i++) begin
            eval("sat");
            tick();
        end
        idle();
        eval("sat_done");
        chk("sat_stall2", {30'd0, b2.stall_cycles}, 32'd3);
        chk("sat_stall16", {16'd0, b16.stall_cycles}, 32'd5);
        tick();

        // Jump squash.
        jump = 1'b1;
        eval("jump");
        chk("jump_IF_ID_flush", {31'd0, b16.IF_ID_flush}, 32'd1);
        tick();

        // Random traffic with small register numbers to provoke matches.
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 24) == 0);
            rs           = 5'($urandom_range(0, 3));
            rt           = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            uses_rt      = 1'($urandom_range(0, 1));
            branch       = 1'($urandom_range(0, 1));
            jump         = ($urandom_range(0, 5) == 0);
            taken        = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            ex_reg_write = 1'($urandom_range(0, 1));
            mm_read      = 1'($urandom_range(0, 1));
            eval("rnd");
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
